// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: opcodes, FSM states,
// instruction classes and datapath mux selects.
package mips_ctrl_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE   = 6'h00;
  localparam logic [OP_W-1:0] OP_J       = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL     = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ     = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE     = 6'h05;
  localparam logic [OP_W-1:0] OP_ALUI_LO = 6'h08;
  localparam logic [OP_W-1:0] OP_ALUI_HI = 6'h0F;
  localparam logic [OP_W-1:0] OP_LB      = 6'h20;
  localparam logic [OP_W-1:0] OP_LW      = 6'h23;
  localparam logic [OP_W-1:0] OP_SB      = 6'h28;
  localparam logic [OP_W-1:0] OP_SW      = 6'h2B;
  localparam logic [OP_W-1:0] FN_JR      = 6'h08;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE  = 3'd0,
    CLS_JR     = 3'd1,
    CLS_ALUI   = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_JUMP   = 3'd6,
    CLS_JAL    = 3'd7
  } cls_t;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  localparam logic [1:0] MEM_SIZE_WORD = 2'b11;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational decode of opcode/funct into an instruction class, an illegal flag
// and the data-memory access size.
module opcode_classifier
  import mips_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  output cls_t            cls,
  output logic            illegal,
  output logic [1:0]      mem_size
);

  always_comb begin
    cls      = CLS_RTYPE;
    illegal  = 1'b0;
    mem_size = MEM_SIZE_WORD;
    case (opcode)
      OP_RTYPE: cls = (funct == FN_JR) ? CLS_JR : CLS_RTYPE;
      OP_J:     cls = CLS_JUMP;
      OP_JAL:   cls = CLS_JAL;
      OP_BEQ,
      OP_BNE:   cls = CLS_BRANCH;
      OP_LB: begin
        cls      = CLS_LOAD;
        mem_size = MEM_SIZE_BYTE;
      end
      OP_LW:    cls = CLS_LOAD;
      OP_SB: begin
        cls      = CLS_STORE;
        mem_size = MEM_SIZE_BYTE;
      end
      OP_SW:    cls = CLS_STORE;
      default: begin
        // Immediate-ALU opcodes occupy one contiguous block.
        if (opcode >= OP_ALUI_LO && opcode <= OP_ALUI_HI) cls = CLS_ALUI;
        else illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB state machine driving every
// datapath select and enable, with a MEM stall timeout and a retired-instruction counter.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [OP_W-1:0]  opcode,
  input  logic [OP_W-1:0]  funct,
  input  logic             alu_branch,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       reg_dst,
  output logic             alu_src,
  output logic [1:0]       wb_sel,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       mem_size,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned STALL_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t             state;
  state_t             state_nxt;
  cls_t               cls_q;
  logic [1:0]         size_q;
  logic [STALL_W-1:0] stall_cnt;
  cls_t               dec_cls;
  logic               dec_illegal;
  logic [1:0]         dec_size;
  logic               retire;
  logic               stall_expired;

  opcode_classifier u_classifier (
    .opcode   (opcode),
    .funct    (funct),
    .cls      (dec_cls),
    .illegal  (dec_illegal),
    .mem_size (dec_size)
  );

  // This cycle is the last tolerated stall; a zero timeout disables the check.
  assign stall_expired = (MEM_TIMEOUT != 0) && (stall_cnt == STALL_W'(MEM_TIMEOUT - 1));

  assign halted   = (state == ST_TRAP);
  assign mem_size = size_q;

  // Next state and Moore outputs; enables are forced low while reset is held.
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SRC_SEQ;
    reg_dst   = REG_DST_RT;
    alu_src   = 1'b0;
    wb_sel    = WB_SEL_ALU;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = ST_DECODE;
        end
        ST_DECODE: state_nxt = dec_illegal ? ST_TRAP : ST_EXEC;
        ST_EXEC: begin
          alu_src = (cls_q inside {CLS_ALUI, CLS_LOAD, CLS_STORE});
          case (cls_q)
            CLS_BRANCH: begin
              pc_write  = alu_branch;
              pc_src    = PC_SRC_BRANCH;
              retire    = 1'b1;
              state_nxt = ST_FETCH;
            end
            CLS_JUMP: begin
              pc_write  = 1'b1;
              pc_src    = PC_SRC_JUMP;
              retire    = 1'b1;
              state_nxt = ST_FETCH;
            end
            CLS_JR: begin
              pc_write  = 1'b1;
              pc_src    = PC_SRC_REG;
              retire    = 1'b1;
              state_nxt = ST_FETCH;
            end
            CLS_JAL: begin
              pc_write  = 1'b1;
              pc_src    = PC_SRC_JUMP;
              reg_write = 1'b1;
              reg_dst   = REG_DST_RA;
              wb_sel    = WB_SEL_PC4;
              retire    = 1'b1;
              state_nxt = ST_FETCH;
            end
            CLS_LOAD,
            CLS_STORE:  state_nxt = ST_MEM;
            default:    state_nxt = ST_WB;
          endcase
        end
        ST_MEM: begin
          mem_read  = (cls_q == CLS_LOAD);
          mem_write = (cls_q == CLS_STORE);
          if (mem_ready) begin
            if (cls_q == CLS_LOAD) begin
              state_nxt = ST_WB;
            end else begin
              retire    = 1'b1;
              state_nxt = ST_FETCH;
            end
          end else if (stall_expired) begin
            state_nxt = ST_TRAP;
          end
        end
        ST_WB: begin
          reg_write = 1'b1;
          reg_dst   = (cls_q == CLS_RTYPE) ? REG_DST_RD : REG_DST_RT;
          wb_sel    = (cls_q == CLS_LOAD) ? WB_SEL_MEM : WB_SEL_ALU;
          retire    = 1'b1;
          state_nxt = ST_FETCH;
        end
        ST_TRAP:  state_nxt = ST_TRAP;
        default:  state_nxt = ST_FETCH;
      endcase
    end
  end

  // State, latched class/size, stall counter and retire counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_FETCH;
      cls_q       <= CLS_RTYPE;
      size_q      <= MEM_SIZE_WORD;
      stall_cnt   <= '0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) begin
        cls_q  <= dec_cls;
        size_q <= dec_size;
      end
      if (state != ST_MEM) begin
        stall_cnt <= '0;
      end else if (!mem_ready && (MEM_TIMEOUT != 0) && !stall_expired) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule
